// File: rtl/occ_lookup.sv
// Occurrence lookup for FM-index backward search: reads the two OCC rows that
// hold the low/high suffix-interval bounds and returns Occ(base, bound) for each.
module occ_lookup #(
  parameter int ROW_W  = 1920,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 18,
  parameter int CNT_W  = 32,
  parameter int SYM_LG = 9,
  localparam int SYMS  = 2 ** SYM_LG,
  localparam int POS_W = ADDR_W + SYM_LG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  in_low,
  input  logic [POS_W-1:0]  in_high,
  input  logic [1:0]        in_base,
  output logic              rEn,
  output logic [ADDR_W-1:0] rAddr0,
  output logic [ADDR_W-1:0] rAddr1,
  input  logic [ROW_W-1:0]  rData0,
  input  logic [ROW_W-1:0]  rData1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  occ_low,
  output logic [CNT_W-1:0]  occ_high,
  output logic              out_err
);

  typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_t;

  state_t state, stateNext;
  logic   accept;
  logic   calcDone;

  logic [ADDR_W-1:0] rowLow, rowHigh;
  logic [SYM_LG-1:0] offLowIn, offHighIn;
  logic              errLow, errHigh;

  logic [SYM_LG-1:0] offLow_p0, offHigh_p0;
  logic [1:0]        base_p0;
  logic              err_p0;

  // Checkpoint count for sym plus the number of sym occurrences before off;
  // the sum wraps at CNT_W bits.
  function automatic logic [CNT_W-1:0] occCount(
    input logic [ROW_W-1:0]  row,
    input logic [1:0]        sym,
    input logic [SYM_LG-1:0] off
  );
    logic [CNT_W-1:0] acc;
    acc = row[int'(sym)*CNT_W +: CNT_W];
    for (int j = 0; j < SYMS; j++) begin
      if ((SYM_LG'(j) < off) && (row[4*CNT_W + 2*j +: 2] == sym))
        acc = acc + CNT_W'(1);
    end
    return acc;
  endfunction

  assign rowLow    = in_low[POS_W-1:SYM_LG];
  assign rowHigh   = in_high[POS_W-1:SYM_LG];
  assign offLowIn  = in_low[SYM_LG-1:0];
  assign offHighIn = in_high[SYM_LG-1:0];
  assign errLow    = int'(rowLow) >= DEPTH;
  assign errHigh   = int'(rowHigh) >= DEPTH;

  assign in_ready  = (state == IDLE);
  assign rEn       = (state == RD);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    calcDone  = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        accept    = 1'b1;
        stateNext = RD;
      end
      RD:   stateNext = CALC;
      CALC: begin
        calcDone  = 1'b1;
        stateNext = OUT;
      end
      OUT:  if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Stage p0: acceptance -- issue row addresses, latch offsets and base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rAddr0 <= '0;
      rAddr1 <= '0;
      err_p0 <= 1'b0;
    end else if (accept) begin
      rAddr0 <= errLow  ? '0 : rowLow;
      rAddr1 <= errHigh ? '0 : rowHigh;
      err_p0 <= errLow | errHigh;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      offLow_p0  <= offLowIn;
      offHigh_p0 <= offHighIn;
      base_p0    <= in_base;
    end
  end

  // Stage p1: rows are present during CALC; results hold through OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_low  <= '0;
      occ_high <= '0;
      out_err  <= 1'b0;
    end else if (calcDone) begin
      occ_low  <= err_p0 ? '0 : occCount(rData0, base_p0, offLow_p0);
      occ_high <= err_p0 ? '0 : occCount(rData1, base_p0, offHigh_p0);
      out_err  <= err_p0;
    end
  end

endmodule

// File: tb/tb_occ_lookup.sv
// Directed bench for occ_lookup: small OCC memory model with registered read,
// hand-computed Occ values, handshake timing and reset-abort checks.
module tb_occ_lookup;

  localparam int ROW_W  = 1920;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 18;
  localparam int CNT_W  = 32;
  localparam int SYM_LG = 9;
  localparam int POS_W  = ADDR_W + SYM_LG;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [POS_W-1:0]  in_low = '0;
  logic [POS_W-1:0]  in_high = '0;
  logic [1:0]        in_base = '0;
  logic              rEn;
  logic [ADDR_W-1:0] rAddr0, rAddr1;
  logic [ROW_W-1:0]  rData0 = '0;
  logic [ROW_W-1:0]  rData1 = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  occ_low, occ_high;
  logic              out_err;

  logic [ROW_W-1:0]  mem [0:DEPTH-1];

  int nVec = 0;
  int nMis = 0;

  occ_lookup #(
    .ROW_W(ROW_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .SYM_LG(SYM_LG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_low(in_low), .in_high(in_high), .in_base(in_base),
    .rEn(rEn), .rAddr0(rAddr0), .rAddr1(rAddr1),
    .rData0(rData0), .rData1(rData1),
    .out_valid(out_valid), .out_ready(out_ready),
    .occ_low(occ_low), .occ_high(occ_high), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rEn) begin
      rData0 <= mem[rAddr0];
      rData1 <= mem[rAddr1];
    end
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, " in_ready"}, in_ready, 1);
    checkVal({tag, " rEn"}, rEn, 0);
    checkVal({tag, " rAddr0"}, rAddr0, 0);
    checkVal({tag, " rAddr1"}, rAddr1, 0);
    checkVal({tag, " out_valid"}, out_valid, 0);
    checkVal({tag, " occ_low"}, occ_low, 0);
    checkVal({tag, " occ_high"}, occ_high, 0);
    checkVal({tag, " out_err"}, out_err, 0);
  endtask

  task automatic doQuery(input logic [POS_W-1:0] lo, input logic [POS_W-1:0] hi,
                         input logic [1:0] b, input logic [CNT_W-1:0] eLo,
                         input logic [CNT_W-1:0] eHi, input logic eErr,
                         input int hold, input string tag);
    logic [ADDR_W-1:0] a0, a1;
    a0 = (lo[POS_W-1:SYM_LG] < 5'd18) ? lo[POS_W-1:SYM_LG] : 5'd0;
    a1 = (hi[POS_W-1:SYM_LG] < 5'd18) ? hi[POS_W-1:SYM_LG] : 5'd0;
    @(negedge clk);
    in_low = lo; in_high = hi; in_base = b; in_valid = 1'b1;
    out_ready = (hold == 0);
    checkVal({tag, " in_ready idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    checkVal({tag, " rEn rd"}, rEn, 1);
    checkVal({tag, " rAddr0"}, rAddr0, a0);
    checkVal({tag, " rAddr1"}, rAddr1, a1);
    checkVal({tag, " in_ready rd"}, in_ready, 0);
    @(negedge clk);
    checkVal({tag, " rEn calc"}, rEn, 0);
    checkVal({tag, " out_valid calc"}, out_valid, 0);
    @(negedge clk);
    checkVal({tag, " out_valid"}, out_valid, 1);
    checkVal({tag, " occ_low"}, occ_low, eLo);
    checkVal({tag, " occ_high"}, occ_high, eHi);
    checkVal({tag, " out_err"}, out_err, eErr);
    checkVal({tag, " in_ready out"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkVal({tag, " hold out_valid"}, out_valid, 1);
      checkVal({tag, " hold occ_low"}, occ_low, eLo);
      checkVal({tag, " hold occ_high"}, occ_high, eHi);
      checkVal({tag, " hold out_err"}, out_err, eErr);
      checkVal({tag, " hold in_ready"}, in_ready, 0);
      checkVal({tag, " hold rEn"}, rEn, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkVal({tag, " out_valid done"}, out_valid, 0);
    checkVal({tag, " in_ready done"}, in_ready, 1);
  endtask

  initial begin
    // Row 0: all zero (counts 0, every symbol A)
    for (int r = 0; r < DEPTH; r++) mem[r] = '0;
    // Row 1: count A=512, symbols C,G,C,G,...
    mem[1][31:0] = 32'd512;
    for (int j = 0; j < 512; j++) mem[1][128 + 2*j +: 2] = (j % 2 == 0) ? 2'd1 : 2'd2;
    // Row 2: counts A=10 C=20 G=30 T=40, symbols A,C,G,T repeating
    mem[2][31:0] = 32'd10; mem[2][63:32] = 32'd20;
    mem[2][95:64] = 32'd30; mem[2][127:96] = 32'd40;
    for (int j = 0; j < 512; j++) mem[2][128 + 2*j +: 2] = 2'(j % 4);
    // Row 17 (last valid): count T at max, all symbols T
    mem[17][127:96] = 32'hFFFF_FFFF;
    for (int j = 0; j < 512; j++) mem[17][128 + 2*j +: 2] = 2'd3;

    #2 rst_n = 1'b0;
    #1 checkReset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    doQuery(14'd0,    14'd100,  2'd0, 32'd0,   32'd100, 1'b0, 0, "row0 A");
    doQuery(14'd512,  14'd517,  2'd1, 32'd0,   32'd3,   1'b0, 0, "row1 C");
    doQuery(14'd512,  14'd517,  2'd0, 32'd512, 32'd512, 1'b0, 0, "row1 A");
    doQuery(14'd1031, 14'd1535, 2'd3, 32'd41,  32'd167, 1'b0, 0, "row2 T");
    doQuery(14'd1124, 14'd1028, 2'd0, 32'd35,  32'd11,  1'b0, 0, "low>high");
    doQuery(14'd1074, 14'd1074, 2'd1, 32'd33,  32'd33,  1'b0, 0, "low=high");
    doQuery(14'd8705, 14'd8704, 2'd3, 32'd0,   32'hFFFF_FFFF, 1'b0, 0, "row17 wrap");
    doQuery(14'd0,    14'd9216, 2'd0, 32'd0,   32'd0,   1'b1, 0, "err high");
    doQuery(14'd15877, 14'd1031, 2'd3, 32'd0,  32'd0,   1'b1, 0, "err low");
    doQuery(14'd1031, 14'd1535, 2'd3, 32'd41,  32'd167, 1'b0, 10, "stall");

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_low = 14'd512; in_high = 14'd517; in_base = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_low = 14'd1074; in_high = 14'd1074; in_base = 2'd1;
    checkVal("b2b rEn q0", rEn, 1);
    checkVal("b2b in_ready rd", in_ready, 0);
    @(negedge clk);
    checkVal("b2b in_ready calc", in_ready, 0);
    checkVal("b2b out_valid calc", out_valid, 0);
    @(negedge clk);
    checkVal("b2b q0 out_valid", out_valid, 1);
    checkVal("b2b q0 occ_low", occ_low, 0);
    checkVal("b2b q0 occ_high", occ_high, 3);
    @(negedge clk);
    checkVal("b2b idle in_ready", in_ready, 1);
    checkVal("b2b idle out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkVal("b2b rEn q1", rEn, 1);
    checkVal("b2b in_ready q1", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    checkVal("b2b q1 out_valid", out_valid, 1);
    checkVal("b2b q1 occ_low", occ_low, 33);
    checkVal("b2b q1 occ_high", occ_high, 33);
    @(negedge clk);
    checkVal("b2b q1 done", out_valid, 0);

    // Reset pulsed while in CALC aborts the query
    @(negedge clk);
    in_low = 14'd1031; in_high = 14'd1535; in_base = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 checkReset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkVal("post-reset out_valid", out_valid, 0);
      checkVal("post-reset in_ready", in_ready, 1);
    end
    doQuery(14'd512, 14'd517, 2'd0, 32'd512, 32'd512, 1'b0, 0, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
